dbg_run_ctrl: RTL and testbench
===============================

Name: dbg_run_ctrl

Overview:
Debug run/step/breakpoint controller for the single-cycle CPU top on the 1 kHz board clock. It turns raw push-button levels into single accepted presses using edge detection and a lockout counter. It sequences the CPU `run` enable through halt/run/single-step/breakpoint states. It also owns the memory/register viewing address and the PC breakpoint register.

Parameters:
LOCK_W, 8, width of the press-lockout counter; lockout lasts 2^LOCK_W-1 cycles after an accepted press
ADDR_W, 8, width of the viewing address
PC_W, 8, width of the CPU PC and of the breakpoint register

Ports:
clk1k  in  1  system clock (1 kHz board clock)
rst  in  1  reset, synchronous, active-low
cont  in  1  continue/pause button level
step  in  1  single-step button level
bp_set  in  1  button level: load breakpoint from addr
inc  in  1  viewing-address increment button level
dec  in  1  viewing-address decrement button level
bp_en  in  1  switch level: breakpoint compare enable
pc  in  PC_W  current CPU PC
run  out  1  CPU clock/run enable
addr  out  ADDR_W  viewing address to CPU top
bp_addr  out  PC_W  breakpoint PC
at_bp  out  1  high while stopped at a breakpoint
state  out  2  FSM state, for LEDs

Behaviour:
- Clock and reset: all state updates on posedge clk1k. Reset is synchronous and active-low: a sampled rst==0 applies the reset values below on that edge.
- Reset values: state=HALT, run=0, at_bp=0, addr=0, bp_addr=0, lockout counter=0, bp_mask=0, button history registers=0.
- Consequence of reset history: a button held through reset release yields exactly one press.
- Press detection, per button: press = level & ~level_q & (lock==0), where level_q is the level registered on the previous edge.
- Priority when several presses occur on the same edge: cont > step > bp_set > inc > dec. Only the winner is acted on.
- inc and dec pressed on the same edge: both ignored and no lockout started, unless a higher-priority button wins.
- Lockout: an accepted press loads lock=1. While lock!=0, lock increments each edge until it wraps to 0. All presses are ignored while lock!=0, and edges during lockout are lost (level_q keeps tracking).
- FSM encoding: HALT=00, RUN=01, STEP=10, BRK=11.
- run decode: run = (state==RUN) | (state==STEP), decoded from the state register only. at_bp = (state==BRK).
- Breakpoint hit condition: bp_hit = bp_en & (pc==bp_addr) & ~bp_mask.
- HALT: cont -> RUN. step -> STEP.
- RUN: bp_hit -> BRK, with priority over a same-edge cont. Otherwise cont -> HALT. step is ignored but still consumes a lockout.
- STEP: unconditionally -> HALT on the next edge, so run is high for exactly one cycle. Presses on that edge are already blocked by the lockout.
- BRK: cont -> RUN and sets bp_mask=1. step -> STEP and sets bp_mask=1.
- bp_mask: cleared on any edge where pc!=bp_addr, so the CPU can leave the breakpoint PC without re-triggering. bp_mask is also cleared on entry to HALT.
- Latency: press sampled at edge k changes state at edge k. run changes after edge k.
- addr: inc -> addr+1, dec -> addr-1, modulo 2^ADDR_W. Accepted in every state.
- bp_set: bp_addr <= addr[PC_W-1:0], zero-extended if ADDR_W<PC_W. Accepted in every state. A new bp_addr takes effect for the compare on the following edge.
- Reset asserted mid-RUN or mid-STEP: run falls after that edge, and lockout and bp_mask clear.

Test Plan:
- Reset with rst=0 for 3 edges -> state=00, run=0, addr=0, bp_addr=0, at_bp=0. Then cont held through rst release -> exactly one press accepted, state=01 after that edge.
- LOCK_W=3, HALT: cont pulse -> run=1 on the next cycle. A second cont rising edge 4 cycles later -> ignored, run stays 1. cont rising edge 8 cycles after the first -> state=00, run=0.
- HALT: step pulse -> run high for exactly 1 cycle, then state=00. Holding step high for 20 cycles -> still only one step.
- inc x3 then dec x5 (each spaced beyond lockout) from addr=0 -> addr=0xFE. inc and dec rising on the same edge -> addr unchanged, next press accepted immediately.
- addr=0x10, bp_set, bp_en=1, cont, pc counts 0x0C..0x10 -> state=11, run=0, at_bp=1 on the edge pc==0x10. Same-edge cont is ignored.
- From BRK at pc=0x10: cont -> state=01 with no re-break while pc=0x10; pc=0x14 then back to 0x10 -> BRK again. Same case with bp_en=0 -> no break.

Source files
------------

// File: rtl/dbg_run_ctrl.sv
// Debug run/step/breakpoint controller for the single-cycle CPU top.
// Turns raw button levels into single accepted presses (edge detect plus
// lockout), sequences the CPU run enable, and owns the viewing address and
// the PC breakpoint register.
module dbg_run_ctrl #(
  parameter int unsigned LOCK_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk1k,
  input  logic              rst,
  input  logic              cont,
  input  logic              step,
  input  logic              bp_set,
  input  logic              inc,
  input  logic              dec,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   pc,
  output logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic [PC_W-1:0]   bp_addr,
  output logic              at_bp,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BRK  = 2'b11
  } state_t;

  state_t            st_q;
  logic [LOCK_W-1:0] lock;
  logic              cont_q, step_q, bp_set_q, inc_q, dec_q;
  logic              bp_mask;

  logic              lock_free;
  logic              p_cont, p_step, p_bp_set, p_inc, p_dec, p_hi;
  logic              w_cont, w_step, w_bp_set, w_inc, w_dec;
  logic              accept;
  logic              bp_hit;
  logic [PC_W-1:0]   bp_src;

  // Breakpoint source: low PC_W bits of addr, zero-extended if addr is narrower
  if (ADDR_W >= PC_W) begin : g_bp_trunc
    assign bp_src = addr[PC_W-1:0];
  end else begin : g_bp_ext
    assign bp_src = {{(PC_W - ADDR_W){1'b0}}, addr};
  end

  // Press detection and fixed-priority arbitration; inc+dec together cancel
  always_comb begin
    lock_free = (lock == '0);
    p_cont    = cont   & ~cont_q   & lock_free;
    p_step    = step   & ~step_q   & lock_free;
    p_bp_set  = bp_set & ~bp_set_q & lock_free;
    p_inc     = inc    & ~inc_q    & lock_free;
    p_dec     = dec    & ~dec_q    & lock_free;
    p_hi      = p_cont | p_step | p_bp_set;
    w_cont    = p_cont;
    w_step    = p_step & ~p_cont;
    w_bp_set  = p_bp_set & ~p_cont & ~p_step;
    w_inc     = p_inc & ~p_dec & ~p_hi;
    w_dec     = p_dec & ~p_inc & ~p_hi;
    accept    = w_cont | w_step | w_bp_set | w_inc | w_dec;
    bp_hit    = bp_en & (pc == bp_addr) & ~bp_mask;
  end

  // Button history and press lockout counter
  always_ff @(posedge clk1k) begin
    if (!rst) begin
      cont_q   <= 1'b0;
      step_q   <= 1'b0;
      bp_set_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      lock     <= '0;
    end else begin
      cont_q   <= cont;
      step_q   <= step;
      bp_set_q <= bp_set;
      inc_q    <= inc;
      dec_q    <= dec;
      if (accept) begin
        lock <= LOCK_W'(1);
      end else if (!lock_free) begin
        lock <= lock + LOCK_W'(1);
      end
    end
  end

  // Viewing address and breakpoint register, accepted in every state
  always_ff @(posedge clk1k) begin
    if (!rst) begin
      addr    <= '0;
      bp_addr <= '0;
    end else begin
      if (w_inc) begin
        addr <= addr + ADDR_W'(1);
      end else if (w_dec) begin
        addr <= addr - ADDR_W'(1);
      end
      if (w_bp_set) begin
        bp_addr <= bp_src;
      end
    end
  end

  // Run-control FSM; bp_mask lets the CPU leave the breakpoint PC after resume
  always_ff @(posedge clk1k) begin
    if (!rst) begin
      st_q    <= HALT;
      bp_mask <= 1'b0;
    end else begin
      // later assignments in the case override this default mask clear
      if (pc != bp_addr) begin
        bp_mask <= 1'b0;
      end
      case (st_q)
        HALT: begin
          if (w_cont) begin
            st_q <= RUN;
          end else if (w_step) begin
            st_q <= STEP;
          end
        end
        RUN: begin
          if (bp_hit) begin
            st_q <= BRK;
          end else if (w_cont) begin
            st_q    <= HALT;
            bp_mask <= 1'b0;
          end
        end
        STEP: begin
          st_q    <= HALT;
          bp_mask <= 1'b0;
        end
        BRK: begin
          if (w_cont) begin
            st_q    <= RUN;
            bp_mask <= 1'b1;
          end else if (w_step) begin
            st_q    <= STEP;
            bp_mask <= 1'b1;
          end
        end
        default: begin
          st_q    <= HALT;
          bp_mask <= 1'b0;
        end
      endcase
    end
  end

  assign state = st_q;
  assign run   = (st_q == RUN) | (st_q == STEP);
  assign at_bp = (st_q == BRK);

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl (LOCK_W=3, so lockout spans 7 cycles).
module tb_dbg_run_ctrl;

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;

  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic       at_bp;
    logic [7:0] addr;
    logic [7:0] bp;
  } obs_t;

  logic       clk1k = 1'b0;
  logic       rst, cont, step, bp_set, inc, dec, bp_en;
  logic [7:0] pc;
  logic       run, at_bp;
  logic [7:0] addr, bp_addr;
  logic [1:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_bp   = 8'h00;
  obs_t        exp_q[$];
  obs_t        got, e;

  dbg_run_ctrl #(.LOCK_W(3), .ADDR_W(8), .PC_W(8)) dut (
    .clk1k(clk1k), .rst(rst), .cont(cont), .step(step), .bp_set(bp_set),
    .inc(inc), .dec(dec), .bp_en(bp_en), .pc(pc), .run(run), .addr(addr),
    .bp_addr(bp_addr), .at_bp(at_bp), .state(state)
  );

  always #5 clk1k = ~clk1k;

  function automatic obs_t mk(input logic [1:0] st);
    obs_t o;
    o.st    = st;
    o.run   = (st == S_RUN) || (st == S_STEP);
    o.at_bp = (st == S_BRK);
    o.addr  = m_addr;
    o.bp    = m_bp;
    return o;
  endfunction

  function automatic obs_t obs();
    obs_t o;
    o.st    = state;
    o.run   = run;
    o.at_bp = at_bp;
    o.addr  = addr;
    o.bp    = bp_addr;
    return o;
  endfunction

  // Queue the expectation for the coming edge, advance, then pop it
  task automatic cyc(input logic [1:0] st);
    exp_q.push_back(mk(st));
    @(posedge clk1k);
    #1;
    got = obs();
    e   = exp_q.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b0; cont = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL reset_values: got %p expected %p", got, e); end
    end
    rst = 1'b1;
    cyc(S_RUN);
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_held_press: got %p expected %p", got, e); end
    for (int i = 0; i < 12; i++) begin
      cyc(S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL reset_single_press: got %p expected %p", got, e); end
    end
    cont = 1'b0;
    cyc(S_RUN);
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_release: got %p expected %p", got, e); end
    cont = 1'b1;
    cyc(S_HALT);
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_pause: got %p expected %p", got, e); end
    cont = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL reset_idle: got %p expected %p", got, e); end
    end
  endtask

  task automatic test_lockout;
    for (int t = 0; t <= 8; t++) begin
      cont = (t == 0 || t == 4 || t == 8);
      cyc((t == 8) ? S_HALT : S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL lockout t=%0d: got %p expected %p", t, got, e); end
    end
    cont = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL lockout_idle: got %p expected %p", got, e); end
    end
  endtask

  task automatic test_step;
    step = 1'b1;
    cyc(S_STEP);
    checks++;
    if (got !== e) begin errors++; $display("FAIL step_pulse: got %p expected %p", got, e); end
    step = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL step_after: got %p expected %p", got, e); end
    end
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc((i == 0) ? S_STEP : S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL step_held i=%0d: got %p expected %p", i, got, e); end
    end
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(S_HALT);
      checks++;
      if (got !== e) begin errors++; $display("FAIL step_idle: got %p expected %p", got, e); end
    end
  endtask

  task automatic test_addr;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) begin inc = 1'b1; m_addr = m_addr + 8'd1; end
      else       begin dec = 1'b1; m_addr = m_addr - 8'd1; end
      cyc(S_HALT);
      inc = 1'b0; dec = 1'b0;
      checks++;
      if (got !== e) begin errors++; $display("FAIL addr_press k=%0d: got %p expected %p", k, got, e); end
      for (int i = 0; i < 8; i++) begin
        cyc(S_HALT);
        checks++;
        if (got !== e) begin errors++; $display("FAIL addr_idle: got %p expected %p", got, e); end
      end
    end
    checks++;
    if (addr !== 8'hFE) begin errors++; $display("FAIL addr_wrap: got %h expected fe", addr); end
    inc = 1'b1; dec = 1'b1;
    cyc(S_HALT);
    checks++;
    if (got !== e) begin errors++; $display("FAIL addr_incdec: got %p expected %p", got, e); end
    inc = 1'b0; dec = 1'b0;
    cyc(S_HALT);
    inc = 1'b1; m_addr = m_addr + 8'd1;
    cyc(S_HALT);
    inc = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL addr_no_lockout: got %p expected %p", got, e); end
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(S_HALT);
        checks++;
        if (got !== e) begin errors++; $display("FAIL addr_walk_idle: got %p expected %p", got, e); end
      end
      inc = 1'b1; m_addr = m_addr + 8'd1;
      cyc(S_HALT);
      inc = 1'b0;
      checks++;
      if (got !== e) begin errors++; $display("FAIL addr_walk: got %p expected %p", got, e); end
    end
    checks++;
    if (addr !== 8'h10) begin errors++; $display("FAIL addr_walk_end: got %h expected 10", addr); end
    for (int i = 0; i < 8; i++) cyc(S_HALT);
  endtask

  task automatic test_breakpoint;
    bp_set = 1'b1; m_bp = 8'h10;
    cyc(S_HALT);
    bp_set = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL bp_load: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) cyc(S_HALT);
    bp_en = 1'b1; pc = 8'h0C; cont = 1'b1;
    cyc(S_RUN);
    cont = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL bp_run: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) begin
      cyc(S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL bp_running: got %p expected %p", got, e); end
    end
    for (int p = 13; p <= 16; p++) begin
      pc = 8'(p);
      cont = (p == 16);
      cyc((p == 16) ? S_BRK : S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL bp_count pc=%h: got %p expected %p", pc, got, e); end
    end
    cont = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(S_BRK);
      checks++;
      if (got !== e) begin errors++; $display("FAIL bp_stopped: got %p expected %p", got, e); end
    end
  endtask

  task automatic test_resume;
    cont = 1'b1;
    cyc(S_RUN);
    cont = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL resume: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) begin
      cyc(S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL resume_masked: got %p expected %p", got, e); end
    end
    pc = 8'h14;
    cyc(S_RUN);
    pc = 8'h10;
    cyc(S_BRK);
    checks++;
    if (got !== e) begin errors++; $display("FAIL rebreak: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) cyc(S_BRK);
    bp_en = 1'b0; cont = 1'b1;
    cyc(S_RUN);
    cont = 1'b0;
    pc = 8'h14;
    cyc(S_RUN);
    pc = 8'h10;
    for (int i = 0; i < 8; i++) begin
      cyc(S_RUN);
      checks++;
      if (got !== e) begin errors++; $display("FAIL bp_disabled: got %p expected %p", got, e); end
    end
    cont = 1'b1;
    cyc(S_HALT);
    cont = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL resume_pause: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) cyc(S_HALT);
  endtask

  task automatic test_back_to_back;
    cont = 1'b1;
    cyc(S_RUN);
    cont = 1'b0;
    cyc(S_RUN);
    rst = 1'b0;
    m_addr = 8'h00; m_bp = 8'h00;
    cyc(S_HALT);
    checks++;
    if (got !== e) begin errors++; $display("FAIL midrun_reset: got %p expected %p", got, e); end
    rst = 1'b1; cont = 1'b1;
    cyc(S_RUN);
    cont = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL lock_cleared: got %p expected %p", got, e); end
    for (int i = 0; i < 8; i++) cyc(S_RUN);
    cont = 1'b1;
    cyc(S_HALT);
    cont = 1'b0;
    checks++;
    if (got !== e) begin errors++; $display("FAIL final_pause: got %p expected %p", got, e); end
  endtask

  initial begin
    rst = 1'b0; cont = 1'b0; step = 1'b0; bp_set = 1'b0;
    inc = 1'b0; dec = 1'b0; bp_en = 1'b0; pc = 8'h00;
    #1;
    test_reset();
    test_lockout();
    test_step();
    test_addr();
    test_breakpoint();
    test_resume();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
